multicycle_core: RTL and testbench

- Parametrised multi-cycle MIPS-subset core: a control FSM sequences fetch/decode/execute/memory/writeback over a shared datapath (register file, ALU, sign-extend, internal instruction and data memories).
- Successor to the hard-wired single-cycle datapath. Adds a real control unit, a program counter, branches/jumps, a loadable instruction memory, halt and debug probes.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/core_regfile.sv | 40 ++++
 rtl/multicycle_core.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared opcodes, state/ALU encodings and the ALU function for the multi-cycle core.
package core_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpHalt  = 6'b111111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b100,
    AluXor = 3'b101,
    AluNor = 3'b110,
    AluSll = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  // Operands arrive sign-extended to 64 bits so SLT is right for any word width;
  // the caller keeps only the low DATA_W bits of the result.
  function automatic logic [63:0] alu_fn(alu_op_e op, logic [63:0] a, logic [63:0] b);
    logic [63:0] res;
    res = '0;
    case (op)
      AluAdd: res = a + b;
      AluSub: res = a - b;
      AluAnd: res = a & b;
      AluOr:  res = a | b;
      AluSlt: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      AluXor: res = a ^ b;
      AluNor: res = ~(a | b);
      AluSll: res = a << b[4:0];
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: two operand read ports, one debug read port, one write port; r0 reads zero.
module core_regfile #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_dbg_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state of the array; r0 forced back to zero after any write.
  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
    regs_d[0] = '0;
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign rdata_a_o   = regs_q[raddr_a_i];
  assign rdata_b_o   = regs_q[raddr_b_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: control FSM over a shared datapath with internal memories.
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  localparam int unsigned RAW       = $clog2(NREGS),
  localparam int unsigned IAW       = $clog2(IMEM_DEPTH),
  localparam int unsigned DAW       = $clog2(DMEM_DEPTH),
  localparam int unsigned PCW       = IAW + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              imem_we,
  input  logic [IAW-1:0]    imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [PCW-1:0]    pc,
  output logic [31:0]       instr_count,
  input  logic [RAW-1:0]    dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data,
  input  logic [DAW-1:0]    dbg_mem_addr,
  output logic [DATA_W-1:0] dbg_mem_data
);

  state_e            state_q, state_d;
  logic [PCW-1:0]    pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       count_q, count_d;
  logic              busy_q, busy_d, halted_q, halted_d;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

  logic [5:0]        op;
  logic              op_legal;
  logic [DATA_W-1:0] imm_ext, addr_sum, rf_a, rf_b, rf_wdata;
  logic [RAW-1:0]    rf_waddr;
  logic [63:0]       alu_res;
  logic [31:0]       br_off;
  logic [27:0]       j_tgt;
  logic [DAW-1:0]    dmem_idx;
  logic              rf_we, dmem_we, retire;

  assign op       = ir_q[31:26];
  assign op_legal = op inside {OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpJ, OpHalt};
  assign imm_ext  = DATA_W'($signed(ir_q[15:0]));
  assign addr_sum = a_q + imm_ext;
  assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_tgt    = {ir_q[25:0], 2'b00};
  assign dmem_idx = alu_out_q[DAW+1:2];
  assign alu_res  = alu_fn(alu_op_e'(ir_q[2:0]), 64'($signed(a_q)), 64'($signed(b_q)));
  assign rf_waddr = (op == OpRtype) ? ir_q[11 +: RAW] : ir_q[16 +: RAW];
  assign rf_wdata = (op == OpLw) ? mdr_q : alu_out_q;

  // Fields the datapath never looks at (shamt, funct[5:3], high ALU bits).
  logic unused_bits;
  assign unused_bits = ^{ir_q, alu_res, br_off, j_tgt};

  core_regfile #(
    .NREGS (NREGS),
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .raddr_a_i  (ir_q[21 +: RAW]),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (ir_q[16 +: RAW]),
    .rdata_b_o  (rf_b),
    .raddr_dbg_i(dbg_reg_addr),
    .rdata_dbg_o(dbg_reg_data),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata)
  );

  // Control FSM next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    rf_we     = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d   = StFetch;
          pc_d      = '0;
          illegal_d = 1'b0;
          count_d   = '0;
        end
      end
      StFetch: begin
        ir_d    = imem[pc_q[PCW-1:2]];
        pc_d    = pc_q + PCW'(4);
        state_d = StDecode;
      end
      StDecode: begin
        a_d = rf_a;
        b_d = rf_b;
        if (op == OpHalt) begin
          state_d = StHalt;
        end else if (!op_legal) begin
          illegal_d = 1'b1;
          retire    = 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (op)
          OpBeq: begin
            // pc_q already holds pc+4 from FETCH.
            if (a_q == b_q) pc_d = pc_q + br_off[PCW-1:0];
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJ: begin
            pc_d    = j_tgt[PCW-1:0];
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpLw, OpSw: begin
            alu_out_d = addr_sum;
            state_d   = StMem;
          end
          OpAddi: begin
            alu_out_d = addr_sum;
            state_d   = StWb;
          end
          default: begin
            alu_out_d = alu_res[DATA_W-1:0];
            state_d   = StWb;
          end
        endcase
      end
      StMem: begin
        if (op == OpSw) begin
          dmem_we = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          mdr_d   = dmem_q[dmem_idx];
          state_d = StWb;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
    if (retire) count_d = count_q + 32'd1;
    busy_d   = !(state_d inside {StIdle, StHalt});
    halted_d = (state_d == StHalt);
  end

  // FSM and datapath registers with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  // Instruction memory load port; survives reset and is locked while running.
  always_ff @(posedge clk) begin
    if (imem_we && !busy_q) imem[imem_waddr] <= imem_wdata;
  end

  // Data memory, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else if (dmem_we) begin
      dmem_q[dmem_idx] <= b_q;
    end
  end

  assign dbg_mem_data = dmem_q[dbg_mem_addr];
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;
  assign pc           = pc_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench: default core plus a 16-bit/8-reg/16-word variant sharing the same stimulus.
module tb_multicycle_core;

  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [31:0] HaltW = 32'hFC00_0000;
  localparam logic [31:0] BadW  = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        rst, start, imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;

  logic        busy, halted, illegal;
  logic [7:0]  pc;
  logic [31:0] instr_count;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [5:0]  dbg_mem_addr;
  logic [31:0] dbg_mem_data;

  logic        busy1, halted1, illegal1;
  logic [7:0]  pc1;
  logic [31:0] count1;
  logic [2:0]  dbg_reg_addr1;
  logic [15:0] dbg_reg_data1;
  logic [3:0]  dbg_mem_addr1;
  logic [15:0] dbg_mem_data1;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  logic [31:0] prog[$];

  always #5 clk = ~clk;

  multicycle_core u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .pc          (pc),
    .instr_count (instr_count),
    .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr),
    .dbg_mem_data(dbg_mem_data)
  );

  multicycle_core #(
    .DATA_W    (16),
    .NREGS     (8),
    .IMEM_DEPTH(64),
    .DMEM_DEPTH(16)
  ) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .busy        (busy1),
    .halted      (halted1),
    .illegal     (illegal1),
    .pc          (pc1),
    .instr_count (count1),
    .dbg_reg_addr(dbg_reg_addr1),
    .dbg_reg_data(dbg_reg_data1),
    .dbg_mem_addr(dbg_mem_addr1),
    .dbg_mem_data(dbg_mem_data1)
  );

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [2:0] fn, logic [4:0] rd, logic [4:0] rs,
                                        logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'b00000, 3'b100, fn};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [63:0] exp);
    dbg_reg_addr = a;
    #1;
    check(tag, 64'(dbg_reg_data), exp);
  endtask

  task automatic chk_mem(input string tag, input logic [5:0] a, input logic [63:0] exp);
    dbg_mem_addr = a;
    #1;
    check(tag, 64'(dbg_mem_data), exp);
  endtask

  task automatic chk_reg1(input string tag, input logic [2:0] a, input logic [63:0] exp);
    dbg_reg_addr1 = a;
    #1;
    check(tag, 64'(dbg_reg_data1), exp);
  endtask

  task automatic chk_mem1(input string tag, input logic [3:0] a, input logic [63:0] exp);
    dbg_mem_addr1 = a;
    #1;
    check(tag, 64'(dbg_mem_data1), exp);
  endtask

  task automatic load_prog;
    foreach (prog[i]) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = 6'(i);
      imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // Leaves the bench at the negedge just after the start edge.
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles after the start edge until HALT is entered, bounded.
  task automatic wait_halt(output int cycles);
    cycles = 0;
    while (!halted && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    check("reached_halt", 64'(halted), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    dbg_reg_addr = '0; dbg_mem_addr = '0; dbg_reg_addr1 = '0; dbg_mem_addr1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    chk_reg("rst_r1", 5'd1, 64'd0);
    chk_mem("rst_m0", 6'd0, 64'd0);

    // ADDI/ADDI/ADD/HALT
    prog = '{enc_i(OpAddi, 5'd0, 5'd1, 16'd5), enc_i(OpAddi, 5'd0, 5'd2, 16'hFFFD),
             enc_r(3'd0, 5'd3, 5'd1, 5'd2), HaltW};
    load_prog();
    pulse_start();
    wait_halt(n);
    check("a_cycles", 64'(n), 64'd14);
    chk_reg("a_r1", 5'd1, 64'd5);
    chk_reg("a_r2", 5'd2, 64'hFFFF_FFFD);
    chk_reg("a_r3", 5'd3, 64'd2);
    check("a_count", 64'(instr_count), 64'd3);
    check("a_pc", 64'(pc), 64'd16);
    check("a_busy", 64'(busy), 64'd0);

    // SW then LW through word 2
    prog = '{enc_i(OpSw, 5'd0, 5'd3, 16'd8), enc_i(OpLw, 5'd0, 5'd4, 16'd8), HaltW};
    load_prog();
    pulse_start();
    wait_halt(n);
    check("b_cycles", 64'(n), 64'd11);
    chk_mem("b_m2", 6'd2, 64'd2);
    chk_reg("b_r4", 5'd4, 64'd2);
    check("b_count", 64'(instr_count), 64'd2);
    check("b_pc", 64'(pc), 64'd12);

    prog = '{enc_i(OpLw, 5'd0, 5'd5, 16'd8), HaltW};
    load_prog();
    pulse_start();
    wait_halt(n);
    check("lw_cycles", 64'(n), 64'd7);
    chk_reg("lw_r5", 5'd5, 64'd2);

    // Countdown loop with BEQ exit and J back
    prog = '{enc_i(OpAddi, 5'd0, 5'd1, 16'd3), enc_i(OpBeq, 5'd1, 5'd0, 16'd2),
             enc_i(OpAddi, 5'd1, 5'd1, 16'hFFFF), enc_j(26'd1), HaltW};
    load_prog();
    pulse_start();
    wait_halt(n);
    check("loop_cycles", 64'(n), 64'd39);
    chk_reg("loop_r1", 5'd1, 64'd0);
    check("loop_pc", 64'(pc), 64'd20);
    check("loop_count", 64'(instr_count), 64'd11);
    check("loop_illegal", 64'(illegal), 64'd0);

    // r0 write, illegal opcode, IMEM write and start while busy
    prog = '{enc_i(OpAddi, 5'd0, 5'd0, 16'd7), BadW, enc_i(OpAddi, 5'd0, 5'd6, 16'd9), HaltW};
    load_prog();
    pulse_start();
    imem_we    = 1'b1;
    imem_waddr = 6'd3;
    imem_wdata = enc_i(OpAddi, 5'd0, 5'd7, 16'd1);
    start      = 1'b1;
    @(negedge clk);
    imem_we = 1'b0;
    start   = 1'b0;
    wait_halt(n);
    check("g_cycles", 64'(n), 64'd11);
    chk_reg("g_r0", 5'd0, 64'd0);
    chk_reg("g_r6", 5'd6, 64'd9);
    chk_reg("g_r7", 5'd7, 64'd0);
    check("g_illegal", 64'(illegal), 64'd1);
    check("g_count", 64'(instr_count), 64'd3);
    pulse_start();
    check("g_illegal_clr", 64'(illegal), 64'd0);
    wait_halt(n);
    check("g_rerun_cycles", 64'(n), 64'd12);
    chk_reg("g_rerun_r7", 5'd7, 64'd0);

    // Reset while the SW sits in MEM
    prog = '{enc_i(OpAddi, 5'd0, 5'd1, 16'h55), enc_i(OpSw, 5'd0, 5'd1, 16'd12), HaltW};
    load_prog();
    pulse_start();
    repeat (7) @(negedge clk);
    check("r_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r_busy", 64'(busy), 64'd0);
    check("r_halted", 64'(halted), 64'd0);
    check("r_pc", 64'(pc), 64'd0);
    check("r_count", 64'(instr_count), 64'd0);
    check("r_illegal", 64'(illegal), 64'd0);
    chk_mem("r_m3", 6'd3, 64'd0);
    chk_mem("r_m2", 6'd2, 64'd0);
    chk_reg("r_r1", 5'd1, 64'd0);
    chk_reg("r_r3", 5'd3, 64'd0);
    pulse_start();
    wait_halt(n);
    check("r_rerun_cycles", 64'(n), 64'd10);
    chk_mem("r_rerun_m3", 6'd3, 64'h55);

    // ALU function coverage
    prog = '{enc_i(OpAddi, 5'd0, 5'd1, 16'd12), enc_i(OpAddi, 5'd0, 5'd2, 16'd10),
             enc_r(3'd1, 5'd3, 5'd1, 5'd2), enc_r(3'd2, 5'd4, 5'd1, 5'd2),
             enc_r(3'd3, 5'd5, 5'd1, 5'd2), enc_r(3'd5, 5'd6, 5'd1, 5'd2),
             enc_r(3'd6, 5'd7, 5'd1, 5'd2), enc_r(3'd7, 5'd8, 5'd1, 5'd2),
             enc_r(3'd4, 5'd9, 5'd2, 5'd1), HaltW};
    load_prog();
    pulse_start();
    wait_halt(n);
    check("alu_cycles", 64'(n), 64'd38);
    chk_reg("alu_sub", 5'd3, 64'd2);
    chk_reg("alu_and", 5'd4, 64'd8);
    chk_reg("alu_or", 5'd5, 64'd14);
    chk_reg("alu_xor", 5'd6, 64'd6);
    chk_reg("alu_nor", 5'd7, 64'hFFFF_FFF1);
    chk_reg("alu_sll", 5'd8, 64'h3000);
    chk_reg("alu_slt", 5'd9, 64'd1);

    // Narrow-width overflow, signed SLT and DMEM wrap
    prog = '{enc_i(OpAddi, 5'd0, 5'd1, 16'h7FFF), enc_i(OpAddi, 5'd1, 5'd1, 16'd1),
             enc_r(3'd4, 5'd2, 5'd1, 5'd0), enc_i(OpSw, 5'd0, 5'd1, 16'd64), HaltW};
    load_prog();
    pulse_start();
    wait_halt(n);
    check("w_cycles", 64'(n), 64'd18);
    check("w16_halted", 64'(halted1), 64'd1);
    check("w16_count", 64'(count1), 64'd4);
    chk_reg1("w16_r1", 3'd1, 64'h8000);
    chk_reg1("w16_r2", 3'd2, 64'd1);
    chk_mem1("w16_m0", 4'd0, 64'h8000);
    chk_reg("w32_r1", 5'd1, 64'h8000);
    chk_reg("w32_r2", 5'd2, 64'd0);
    chk_mem("w32_m16", 6'd16, 64'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
